// File: rtl/rv32i_dmem_bus.sv
// Data-memory bus master: turns load/store requests from the memory stage into one
// strobe/ack bus cycle at a time, stalls the core meanwhile and reports ack/error/timeout.
module rv32i_dmem_bus #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        stall,
    output logic        o_stb,
    output logic        o_we,
    output logic [31:0] o_addr,
    output logic [31:0] o_data,
    output logic [3:0]  o_sel,
    input  logic        i_ack,
    input  logic        i_err,
    input  logic [31:0] i_data
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic            stall_s;
    logic            unused_s;

    // Byte offset is consumed by the memory stage, not by the bus.
    assign unused_s = ^addr[1:0];

    // Stall decode: the only combinational output; forced low while reset is held.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            IDLE:    stall_s = rd_req | wr_req;
            BUSY:    stall_s = 1'b1;
            RESP:    stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    assign stall = rst_n & stall_s;

    // Transaction FSM with registered bus and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            o_stb   <= 1'b0;
            o_we    <= 1'b0;
            o_addr  <= 32'h0000_0000;
            o_data  <= 32'h0000_0000;
            o_sel   <= 4'h0;
            rdata   <= 32'h0000_0000;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    rdata <= 32'h0000_0000;
                    cnt_r <= '0;
                    if (wr_req) begin
                        o_addr <= {addr[31:2], 2'b00};
                        o_data <= wdata;
                        o_sel  <= wmask;
                        if (wmask == 4'h0) begin
                            // Empty byte mask: complete without touching the bus.
                            o_stb   <= 1'b0;
                            o_we    <= 1'b0;
                            done    <= 1'b1;
                            state_r <= RESP;
                        end else begin
                            o_stb   <= 1'b1;
                            o_we    <= 1'b1;
                            state_r <= BUSY;
                        end
                    end else if (rd_req) begin
                        o_addr  <= {addr[31:2], 2'b00};
                        o_data  <= wdata;
                        o_sel   <= 4'hF;
                        o_stb   <= 1'b1;
                        o_we    <= 1'b0;
                        state_r <= BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (i_err || (!i_ack && (cnt_r == LAST_CNT))) begin
                        rdata   <= 32'h0000_0000;
                        err     <= 1'b1;
                        done    <= 1'b1;
                        o_stb   <= 1'b0;
                        o_we    <= 1'b0;
                        state_r <= RESP;
                    end else if (i_ack) begin
                        rdata   <= o_we ? 32'h0000_0000 : i_data;
                        err     <= 1'b0;
                        done    <= 1'b1;
                        o_stb   <= 1'b0;
                        o_we    <= 1'b0;
                        state_r <= RESP;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                        state_r <= BUSY;
                    end
                end
                RESP: begin
                    done    <= 1'b0;
                    err     <= 1'b0;
                    rdata   <= 32'h0000_0000;
                    state_r <= IDLE;
                end
                default: begin
                    o_stb   <= 1'b0;
                    o_we    <= 1'b0;
                    done    <= 1'b0;
                    err     <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule
